cypher_decryptor: RTL and testbench

- Receive end of the Encryptor's `cypher` byte stream; recovers plaintext bytes.
- Input convention matches the Encryptor side: `cypher_in` is 8 bits, sampled every clock, and a nonzero value means one valid byte. 0x00 means idle.
- Each valid byte is XORed with a keystream from an 8-bit Galois LFSR, buffered in a small FIFO, and presented on a valid/ready output port.
- Also tracks message length, completion and overflow status for the bench or downstream logic.

---
 rtl/cypher_pkg.sv | 22 ++
 rtl/cypher_decryptor_if.sv | 31 +++
 rtl/cypher_fifo.sv | 62 ++++++
 rtl/cypher_decryptor.sv | 76 +++++++
 tb/tb_cypher_decryptor.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/cypher_pkg.sv
// ============================================================================
// cypher_pkg : types, constants and keystream step shared by both cypher ends
// Revision   : 1.0
// ============================================================================
`default_nettype none

package cypher_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t CYPHER_SEED = 8'hA5;
  localparam byte_t CYPHER_POLY = 8'hB8;
  localparam byte_t CYPHER_IDLE = 8'h00;

  // One Galois LFSR shift: the bit leaving at the bottom folds the tap mask back in.
  function automatic byte_t lfsr_step(input byte_t k, input byte_t poly = CYPHER_POLY);
    return (k >> 1) ^ (k[0] ? poly : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cypher_decryptor_if.sv
// ============================================================================
// cypher_decryptor_if : cypher input byte plus plaintext valid/ready port
// Revision            : 1.0
// ============================================================================
`default_nettype none

interface cypher_decryptor_if;
  import cypher_pkg::*;

  byte_t cypher_in;
  byte_t plain_data;
  logic  plain_valid;
  logic  plain_ready;

  modport master (
    input  cypher_in,
    input  plain_ready,
    output plain_data,
    output plain_valid
  );

  modport slave (
    output cypher_in,
    output plain_ready,
    input  plain_data,
    input  plain_valid
  );

endinterface

`default_nettype wire

// File: rtl/cypher_fifo.sv
// ============================================================================
// cypher_fifo : synchronous FIFO with flush; head output holds when empty
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cypher_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             flush,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] din,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] hold;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  // hold tracks the head so the output keeps its last value once drained.
  assign dout = empty ? hold : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      hold   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (!empty)  hold   <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/cypher_decryptor.sv
// ============================================================================
// cypher_decryptor : LFSR-keyed XOR decryption into a buffered plaintext port
// Revision         : 1.0
// ============================================================================
`default_nettype none

import cypher_pkg::*;

module cypher_decryptor #(
  parameter byte_t SEED       = CYPHER_SEED,
  parameter byte_t POLY       = CYPHER_POLY,
  parameter int    MSG_LEN    = 16,
  parameter int    FIFO_DEPTH = 8
) (
  input  wire logic           clk,
  input  wire logic           rst,
  input  wire logic           restart,
  cypher_decryptor_if.master  cyp,
  output byte_t               byte_count,
  output logic                done,
  output logic                overflow
);

  localparam byte_t LAST_IDX = byte_t'(MSG_LEN - 1);

  byte_t key;
  byte_t plain;
  logic  accept;
  logic  pop;
  logic  full;
  logic  empty;

  assign accept = (cyp.cypher_in != CYPHER_IDLE) && !done && !restart;
  assign pop    = cyp.plain_valid && cyp.plain_ready;
  assign plain  = cyp.cypher_in ^ key;

  // Key and count advance even on a dropped byte to stay in step with the sender.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key        <= SEED;
      byte_count <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else if (restart) begin
      key        <= SEED;
      byte_count <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else if (accept) begin
      key        <= lfsr_step(key, POLY);
      byte_count <= byte_count + 8'd1;
      if (byte_count == LAST_IDX) done     <= 1'b1;
      if (full && !pop)           overflow <= 1'b1;
    end
  end

  cypher_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (restart),
    .push  (accept),
    .din   (plain),
    .pop   (cyp.plain_ready),
    .dout  (cyp.plain_data),
    .full  (full),
    .empty (empty)
  );

  assign cyp.plain_valid = !empty;

endmodule

`default_nettype wire

// File: tb/tb_cypher_decryptor.sv
// ============================================================================
// tb_cypher_decryptor : scoreboard bench with a message-level reference model
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_cypher_decryptor;
  import cypher_pkg::*;

  localparam int MSG_LEN    = 16;
  localparam int FIFO_DEPTH = 8;

  logic  clk;
  logic  rst;
  logic  restart;
  byte_t byte_count;
  logic  done;
  logic  overflow;

  cypher_decryptor_if cyp ();

  cypher_decryptor #(
    .SEED       (8'hA5),
    .POLY       (8'hB8),
    .MSG_LEN    (MSG_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .cyp        (cyp.master),
    .byte_count (byte_count),
    .done       (done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  byte_t ks [256];
  int    mcount;
  bit    mdone;
  bit    movf;
  int    occ;
  byte_t exp_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mcount = 0;
    mdone  = 1'b0;
    movf   = 1'b0;
    occ    = 0;
    exp_q.delete();
  endtask

  // Check state left by the previous edge, then drive the next cycle's inputs.
  task automatic step(input byte_t c, input bit rdy, input bit rs);
    bit pop;
    bit push;
    @(posedge clk);
    #2;
    chk("byte_count", int'(byte_count), mcount);
    chk("done", int'(done), int'(mdone));
    chk("overflow", int'(overflow), int'(movf));
    chk("plain_valid", int'(cyp.plain_valid), int'(occ > 0));
    cyp.cypher_in   = c;
    cyp.plain_ready = rdy;
    restart         = rs;
    if (rs) begin
      model_clear();
    end else begin
      pop  = rdy && (occ > 0);
      push = 1'b0;
      if (c != 8'h00 && !mdone) begin
        if (occ < FIFO_DEPTH || pop) begin
          push = 1'b1;
          exp_q.push_back(c ^ ks[mcount]);
        end else begin
          movf = 1'b1;
        end
        mcount++;
        if (mcount == MSG_LEN) mdone = 1'b1;
      end
      occ = occ + int'(push) - int'(pop);
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("reset plain_valid", int'(cyp.plain_valid), 0);
    chk("reset plain_data", int'(cyp.plain_data), 0);
    chk("reset byte_count", int'(byte_count), 0);
    chk("reset done", int'(done), 0);
    chk("reset overflow", int'(overflow), 0);
    model_clear();
    cyp.cypher_in   = 8'h00;
    cyp.plain_ready = 1'b1;
    restart         = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(8'h00, rdy, 1'b0);
  endtask

  // Monitor: a pop happens on the coming edge whenever valid && ready here.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && !restart && cyp.plain_valid && cyp.plain_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got 0x%0h expected none at %0t", cyp.plain_data, $time);
        end else begin
          chk("plain_data", int'(cyp.plain_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    ks[0] = 8'hA5;
    for (int i = 1; i < 256; i++)
      ks[i] = (ks[i-1] >> 1) ^ (ks[i-1][0] ? 8'hB8 : 8'h00);
    model_clear();

    rst             = 1'b0;
    restart         = 1'b0;
    cyp.cypher_in   = 8'h00;
    cyp.plain_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("init plain_valid", int'(cyp.plain_valid), 0);
    chk("init plain_data", int'(cyp.plain_data), 0);
    chk("init byte_count", int'(byte_count), 0);
    rst = 1'b1;

    // "Hi!" back to back, then with idle gaps
    step(8'hED, 1, 0); step(8'h83, 1, 0); step(8'h54, 1, 0);
    idle(2, 1);
    step(8'h00, 1, 1);
    step(8'hED, 1, 0); idle(2, 1); step(8'h83, 1, 0); idle(1, 1); step(8'h54, 1, 0);
    idle(2, 1);

    // Overflow with ready low, then one byte with ready high
    step(8'h00, 1, 1);
    for (int i = 0; i < 9; i++) step(8'($urandom_range(1, 255)), 0, 0);
    step(8'($urandom_range(1, 255)), 1, 0);
    idle(10, 1);

    // Full FIFO with simultaneous push and pop
    step(8'h00, 1, 1);
    for (int i = 0; i < FIFO_DEPTH; i++) step(8'($urandom_range(1, 255)), 0, 0);
    step(8'($urandom_range(1, 255)), 1, 0);
    idle(1, 0);
    idle(10, 1);

    // Complete message, ignored extra byte, restart with a discarded byte
    step(8'h00, 1, 1);
    for (int i = 0; i < MSG_LEN + 1; i++) step(8'($urandom_range(1, 255)), 1, 0);
    idle(2, 1);
    step(8'hED, 1, 1);
    step(8'hED, 1, 0);
    idle(2, 1);

    // Asynchronous reset mid-message
    step(8'h00, 1, 1);
    for (int i = 0; i < 5; i++) step(8'($urandom_range(1, 255)), 0, 0);
    async_reset();
    step(8'hED, 1, 0);
    idle(2, 1);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      byte_t c;
      c = ($urandom_range(0, 9) < 4) ? 8'h00 : 8'($urandom_range(1, 255));
      step(c, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end

    idle(FIFO_DEPTH + 4, 1);
    chk("drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
